process_scheduler: RTL
======================

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 SHALL have parameter NPROC, default 4, number of process slots (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 13, program counter width.
REQ-003 SHALL have parameter QUANTUM_RST, default 16'd1000, quantum length loaded at reset.
REQ-004 SHALL have port Sys_Clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_I  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port Enable  in  1  preemptive scheduling enable.
REQ-007 SHALL have port Quantum_Load  in  1  1-cycle strobe; latch Quantum_Value.
REQ-008 SHALL have port Quantum_Value  in  16  new quantum length, in cycles.
REQ-009 SHALL have port Proc_Create  in  1  1-cycle strobe; create a process.
REQ-010 SHALL have port Create_ID  in  log2(NPROC)  slot index for Proc_Create.
REQ-011 SHALL have port Create_PC  in  PC_W  start PC for the created process.
REQ-012 SHALL have port Cur_PC  in  PC_W  PC to resume the running process at.
REQ-013 SHALL have port Yield  in  1  running process gives up the CPU.
REQ-014 SHALL have port Halt  in  1  running process terminates.
REQ-015 SHALL have port Ack  in  1  datapath has loaded New_PC.
REQ-016 SHALL have port Switch_Req  out  1  request for the PC to load New_PC.
REQ-017 SHALL have port New_PC  out  PC_W  PC of the selected process.
REQ-018 SHALL have port Cur_Proc  out  log2(NPROC)  running or selected slot.
REQ-019 SHALL have port Active_Mask  out  NPROC  one bit per live slot.
REQ-020 SHALL have port Idle  out  1  no process is running.
REQ-021 SHALL have port Err  out  1  1-cycle pulse on a rejected create.

Function
REQ-022 SHALL keep the following internal state: PC table of NPROC x PC_W, Active_Mask, a 16-bit quantum register, a 16-bit down-counter and an FSM with states IDLE, RUN, SAVE, SELECT, LOAD.
REQ-023 SHALL latch Quantum_Load in any state, storing Quantum_Value==0 as 1; the counter picks up the new value only at its next reload.
REQ-024 SHALL accept Proc_Create in any state when Active_Mask[Create_ID]==0: table[Create_ID] <= Create_PC and the mask bit sets on the next edge.
REQ-025 SHALL ignore Proc_Create when the slot is already active, change no state, and pulse Err for one cycle.
REQ-026 SHALL, in IDLE, assert Idle=1; with Enable=1 and Active_Mask!=0 it SHALL go to SELECT on the next cycle, otherwise stay in IDLE.
REQ-027 SHALL, in RUN, decrement the counter each cycle Enable=1 and freeze it when Enable=0.
REQ-028 SHALL, in RUN, go to SAVE on the next cycle on Halt, Yield, or counter==0 with Enable=1.
REQ-029 SHALL give Halt priority over Yield and Yield priority over expiry.
REQ-030 SHALL, in SAVE on Halt, clear Active_Mask[Cur_Proc] and leave the table unchanged.
REQ-031 SHALL, in SAVE on Yield or expiry, write table[Cur_Proc] <= Cur_PC; SAVE SHALL last exactly 1 cycle and then go to SELECT.
REQ-032 SHALL, in SELECT (1 cycle), search round-robin for the first active slot starting at Cur_Proc+1 modulo NPROC and wrapping back to Cur_Proc itself.
REQ-033 SHALL go from SELECT to LOAD and set Cur_Proc to the found slot; if no slot is active it SHALL go to IDLE with Cur_Proc unchanged.
REQ-034 SHALL, in LOAD, hold Switch_Req=1 and New_PC=table[Cur_Proc] stable until the first cycle with Ack=1.
REQ-035 SHALL, on the edge that samples Ack=1 in LOAD, go to RUN, reload the counter from the quantum register and drive Switch_Req=0 from the next cycle.
REQ-036 SHALL ignore Ack outside LOAD.
REQ-037 SHALL ignore Yield and Halt outside RUN.
REQ-038 SHALL re-select a process that is the only active slot when it yields or expires: it passes through SAVE, SELECT and LOAD and resumes at its saved PC.
REQ-039 SHALL, on create and Halt in the same cycle for the running slot, process the Halt first and reject the create with Err because the bit is still set.
REQ-040 SHALL hold Idle=0 in every state except IDLE.
REQ-041 SHALL keep Active_Mask and the table unchanged when Enable falls mid-switch; only counting stops.
REQ-042 SHALL keep the switch latency from the event cycle to Switch_Req=1 at exactly 3 cycles (RUN, SAVE, SELECT, then LOAD).

Reset
REQ-043 SHALL, on Reset_I=0 at a clock edge, enter IDLE regardless of state, including mid-LOAD.
REQ-044 SHALL on reset clear Active_Mask, Cur_Proc, Switch_Req, New_PC and Err to 0 and set Idle=1.
REQ-045 SHALL on reset load the quantum register with QUANTUM_RST and the counter with 0.
REQ-046 SHALL not clear the table on reset; its contents are don't-care until a slot is created.

Verification
REQ-047 SHALL be verified by the scenario: reset, create slot 0 at PC 0x010, Enable=1 -> Idle falls, Switch_Req=1 and New_PC=0x010 with Cur_Proc=0; Ack -> RUN.
REQ-048 SHALL be verified by the scenario: slots 0 (PC 0x010) and 2 (PC 0x200) active, quantum 4, running slot 0, Cur_PC=0x014 at expiry -> New_PC=0x200 and Cur_Proc=2; after the next expiry New_PC=0x014 and Cur_Proc=0.
REQ-049 SHALL be verified by the scenario: Halt and Yield asserted together in RUN on the sole active slot -> its mask bit clears, Idle=1, and no Switch_Req occurs.
REQ-050 SHALL be verified by the scenario: create slot 1 twice -> the second create pulses Err for 1 cycle and table[1] keeps its first PC.
REQ-051 SHALL be verified by the scenario: Ack held low 10 cycles in LOAD, then Reset_I=0 -> Switch_Req stays 1 and New_PC stays stable throughout, then all outputs return to their reset values on the next edge.
REQ-052 SHALL be verified by the scenario: Quantum_Value=0 loaded, one process created -> expiry occurs every cycle in RUN, so the switch loop repeats with 1 RUN cycle per pass while Ack is held 1.

Source files
------------

// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: per-slot PC table, quantum timer and
// a five-state context-switch FSM that hands New_PC to the datapath.
module process_scheduler #(
  parameter int          NPROC       = 4,
  parameter int          PC_W        = 13,
  parameter logic [15:0] QUANTUM_RST = 16'd1000
) (
  input  logic                     Sys_Clock,
  input  logic                     Reset_I,
  input  logic                     Enable,
  input  logic                     Quantum_Load,
  input  logic [15:0]              Quantum_Value,
  input  logic                     Proc_Create,
  input  logic [$clog2(NPROC)-1:0] Create_ID,
  input  logic [PC_W-1:0]          Create_PC,
  input  logic [PC_W-1:0]          Cur_PC,
  input  logic                     Yield,
  input  logic                     Halt,
  input  logic                     Ack,
  output logic                     Switch_Req,
  output logic [PC_W-1:0]          New_PC,
  output logic [$clog2(NPROC)-1:0] Cur_Proc,
  output logic [NPROC-1:0]         Active_Mask,
  output logic                     Idle,
  output logic                     Err
);

  // state  | meaning
  // IDLE   | no process running; wait for Enable and a live slot
  // RUN    | process owns the CPU; quantum counts down while Enable=1
  // SAVE   | store Cur_PC (yield/expiry) or retire the slot (halt)
  // SELECT | round-robin search for the next live slot after Cur_Proc
  // LOAD   | present New_PC with Switch_Req until Ack
  localparam int ID_W = $clog2(NPROC);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SAVE, S_SELECT, S_LOAD} state_t;

  state_t            state_q, state_d;
  logic [NPROC-1:0]  mask_q, mask_d;
  logic [ID_W-1:0]   cur_q;
  logic [15:0]       quantum_q;
  logic [15:0]       cnt_q;
  logic              err_q;
  logic              halt_q;
  logic [PC_W-1:0]   table_q [NPROC];

  logic              create_ok, create_bad, expire;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx, cand;

  assign create_ok  = Proc_Create && !mask_q[Create_ID];
  assign create_bad = Proc_Create &&  mask_q[Create_ID];
  // Expiry fires on the enabled cycle whose decrement reaches zero, so a
  // quantum of N grants exactly N enabled RUN cycles.
  assign expire     = Enable && (cnt_q <= 16'd1);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = cur_q;
    cand      = '0;
    for (int i = 1; i <= NPROC; i++) begin
      cand = cur_q + ID_W'(i);
      if (!sel_found && mask_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (create_ok) mask_d[Create_ID] = 1'b1;
    if (state_q == S_SAVE && halt_q) mask_d[cur_q] = 1'b0;
  end

  always_ff @(posedge Sys_Clock) begin
    if (!Reset_I) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      cur_q     <= '0;
      quantum_q <= QUANTUM_RST;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= create_bad;
      if (Quantum_Load) quantum_q <= (Quantum_Value == 16'd0) ? 16'd1 : Quantum_Value;
      if (state_q == S_RUN) begin
        halt_q <= Halt;
        if (Enable && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
      end
      if (state_q == S_LOAD && Ack) cnt_q <= quantum_q;
      if (state_q == S_SELECT && sel_found) cur_q <= sel_idx;
    end
  end

  // Table is not reset; a slot's entry is written before its mask bit can be seen.
  always_ff @(posedge Sys_Clock) begin
    if (Reset_I) begin
      if (create_ok) table_q[Create_ID] <= Create_PC;
      if (state_q == S_SAVE && !halt_q) table_q[cur_q] <= Cur_PC;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Enable && (|mask_q)) state_d = S_SELECT;
      S_RUN:    if (Halt || Yield || expire) state_d = S_SAVE;
      S_SAVE:   state_d = S_SELECT;
      S_SELECT: state_d = sel_found ? S_LOAD : S_IDLE;
      S_LOAD:   if (Ack) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Switch_Req  = (state_q == S_LOAD);
    New_PC      = (state_q == S_LOAD) ? table_q[cur_q] : '0;
    Idle        = (state_q == S_IDLE);
    Cur_Proc    = cur_q;
    Active_Mask = mask_q;
    Err         = err_q;
  end

endmodule
